mul_div_unit: RTL and testbench

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/mdu_pkg.sv | 30 +++
 rtl/mdu_divider.sv | 56 +++++
 rtl/mul_div_unit.sv | 186 ++++++++++++++++++
 tb/tb_mul_div_unit.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit.
//   op_e    : operation encodings carried on the op port
//   state_e : control FSM states
//   ITER_CNT: iterations per multiply or divide (one operand bit per cycle)
//   mag32   : two's-complement magnitude helper used for the signed operations
package mdu_pkg;

  localparam int ITER_CNT = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  // Magnitude of v when it is to be read as negative; 0x80000000 maps to
  // itself, which is the correct unsigned magnitude.
  function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_neg);
    return is_neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/mdu_divider.sv
// Restoring divider datapath on unsigned magnitudes, one quotient bit per step.
// Ports:
//   clk, rst     : clock, asynchronous active-low reset
//   load         : capture dividend/divisor and clear the partial remainder
//   step         : commit one restoring iteration
//   dividend     : unsigned dividend magnitude
//   divisor      : unsigned divisor magnitude (nonzero when loaded)
//   quo_next     : quotient register value after the current iteration
//   rem_next     : remainder register value after the current iteration
// The *_next values are exposed so the controller can latch the final
// result on the same edge that commits the last iteration.
module mdu_divider (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quo_next,
  output logic [31:0] rem_next
);

  logic [31:0] quo;
  logic [31:0] rem;
  logic [31:0] dsr;
  logic [32:0] shifted;
  logic        ge;

  // Shift the next dividend bit into the partial remainder and try a
  // subtraction. When it fits the result is < divisor, so 32 bits suffice
  // and the modular subtract is exact.
  assign shifted  = {rem, quo[31]};
  assign ge       = shifted >= {1'b0, dsr};
  assign rem_next = ge ? (shifted[31:0] - dsr) : shifted[31:0];
  assign quo_next = {quo[30:0], ge};

  // NOTE: datapath registers are reset too; they are few and it keeps
  // simulation free of X on the unused-state outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      quo <= '0;
      rem <= '0;
      dsr <= '0;
    end else if (load) begin
      quo <= dividend;
      rem <= '0;
      dsr <= divisor;
    end else if (step) begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      quo <= quo_next;
      rem <= rem_next;
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative 32-bit multiply/divide unit (MULT, MULTU, DIV, DIVU) producing a
// HI/LO pair. Multiply is a radix-2 shift-add, divide is restoring; both run
// on magnitudes for 32 cycles with the sign fixed up when the result is
// latched. Divide by zero completes immediately with lo=all-ones, hi=src_a.
// Ports:
//   clk, rst     : clock, asynchronous active-low reset
//   start        : request, accepted only when idle and cancel is low
//   op           : 00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   src_a, src_b : multiplicand/dividend, multiplier/divisor
//   cancel       : flush; abandons the operation in flight
//   busy         : high in any state other than idle
//   done         : one-cycle result-valid pulse
//   hi_o, lo_o   : product[63:32]/remainder, product[31:0]/quotient
//   hi_we, lo_we : HI/LO write enables, identical to done
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             hi_we,
  output logic             lo_we
);

  state_e       state;
  logic [5:0]   iter;
  logic         busy_q;
  logic         done_q;
  logic         res_neg;   // product sign, or quotient sign
  logic         rem_neg;   // remainder sign (follows the dividend)
  logic [63:0]  prod;      // {partial sum, remaining multiplier bits}
  logic [31:0]  mcand;
  logic [31:0]  hi_q;
  logic [31:0]  lo_q;

  logic         accept;
  logic         is_div;
  logic         is_signed;
  logic         a_neg;
  logic         b_neg;
  logic [31:0]  a_mag;
  logic [31:0]  b_mag;
  logic         last;

  logic [32:0]  mul_sum;
  logic [63:0]  prod_step;
  logic [63:0]  prod_final;

  logic         div_load;
  logic         div_step;
  logic [31:0]  quo_next;
  logic [31:0]  rem_next;
  logic [31:0]  quo_final;
  logic [31:0]  rem_final;

  // Request decode; cancel in the same cycle wins over start.
  assign accept    = start && !cancel && (state == S_IDLE);
  assign is_div    = op[1];
  assign is_signed = (op == OP_MULT) || (op == OP_DIV);
  assign a_neg     = is_signed && src_a[31];
  assign b_neg     = is_signed && src_b[31];
  assign a_mag     = mag32(src_a, a_neg);
  assign b_mag     = mag32(src_b, b_neg);
  assign last      = (iter == 6'(ITER_CNT - 1));

  // Shift-add step: conditionally add the multiplicand into the upper half,
  // then shift the whole register right; the carry becomes the new MSB.
  assign mul_sum    = {1'b0, prod[63:32]} + {1'b0, mcand};
  assign prod_step  = prod[0] ? {mul_sum, prod[31:1]} : {1'b0, prod[63:1]};
  assign prod_final = res_neg ? (~prod_step + 64'd1) : prod_step;

  assign div_load  = accept && is_div && (src_b != '0);
  assign div_step  = (state == S_DIV) && !cancel;
  assign quo_final = res_neg ? (~quo_next + 32'd1) : quo_next;
  assign rem_final = rem_neg ? (~rem_next + 32'd1) : rem_next;

  mdu_divider u_divider (
    .clk      (clk),
    .rst      (rst),
    .load     (div_load),
    .step     (div_step),
    .dividend (a_mag),
    .divisor  (b_mag),
    .quo_next (quo_next),
    .rem_next (rem_next)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      iter    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      res_neg <= 1'b0;
      rem_neg <= 1'b0;
      prod    <= '0;
      mcand   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            res_neg <= a_neg ^ b_neg;
            rem_neg <= a_neg;
            iter    <= '0;
            busy_q  <= 1'b1;
            if (!is_div) begin
              prod  <= {32'd0, b_mag};
              mcand <= a_mag;
              state <= S_MUL;
            end else if (src_b == '0) begin
              hi_q   <= src_a;
              lo_q   <= '1;
              done_q <= 1'b1;
              state  <= S_DONE;
            end else begin
              state <= S_DIV;
            end
          end
        end

        S_MUL: begin
          if (cancel) begin
            busy_q <= 1'b0;
            state  <= S_IDLE;
          end else begin
            prod <= prod_step;
            iter <= iter + 6'd1;
            if (last) begin
              hi_q   <= prod_final[63:32];
              lo_q   <= prod_final[31:0];
              done_q <= 1'b1;
              state  <= S_DONE;
            end
          end
        end

        S_DIV: begin
          if (cancel) begin
            busy_q <= 1'b0;
            state  <= S_IDLE;
          end else begin
            iter <= iter + 6'd1;
            if (last) begin
              hi_q   <= rem_final;
              lo_q   <= quo_final;
              done_q <= 1'b1;
              state  <= S_DONE;
            end
          end
        end

        S_DONE: begin
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end

        default: begin
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  // A flush arriving while the pulse is up still suppresses the writes.
  assign busy  = busy_q;
  assign done  = done_q && !cancel;
  assign hi_we = done;
  assign lo_we = done;
  assign hi_o  = hi_q;
  assign lo_o  = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed vector table, randomized
// operations against an arithmetic reference model, and hand-written
// sequences for busy, cancel and reset corner cases.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        cancel;
  logic        busy;
  logic        done;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        hi_we;
  logic        lo_we;

  int checks = 0;
  int errors = 0;

  logic [31:0] last_hi;
  logic [31:0] last_lo;

  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[7];

  mul_div_unit #(.WIDTH(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .src_a  (src_a),
    .src_b  (src_b),
    .cancel (cancel),
    .busy   (busy),
    .done   (done),
    .hi_o   (hi_o),
    .lo_o   (lo_o),
    .hi_we  (hi_we),
    .lo_we  (lo_we)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: plain 64-bit arithmetic on the architectural meaning.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'b00: begin p = 64'(sa * sb); return p; end
      2'b01: begin p = {32'd0, a} * {32'd0, b}; return p; end
      default: begin
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (o == 2'b10) begin
          q = sa / sb;            // truncates toward zero
          r = sa % sb;            // sign of the dividend
        end else begin
          q = longint'({32'd0, a}) / longint'({32'd0, b});
          r = longint'({32'd0, a}) % longint'({32'd0, b});
        end
        return {32'(r), 32'(q)};
      end
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Counts edges until done, bounded; returns 99 on timeout.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 40) begin
      tick();
      lat++;
    end
    if (!done) lat = 99;
  endtask

  task automatic expect_quiet(input string name, input int cycles);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (done || hi_we || lo_we) seen++;
    end
    check({name, "_no_done"}, seen, 0);
  endtask

  // Issues one operation from idle and checks latency, result and pulse width.
  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo);
    int lat;
    int exp_lat;
    exp_lat = (o[1] && b == 32'd0) ? 0 : 32;
    start = 1'b1; op = o; src_a = a; src_b = b;
    tick();
    // Scramble inputs to prove the operands were captured at the accept edge.
    start = 1'b0; op = 2'($urandom); src_a = $urandom; src_b = $urandom;
    wait_done(lat);
    check({name, "_latency"}, lat, exp_lat);
    check({name, "_hi"}, hi_o, ehi);
    check({name, "_lo"}, lo_o, elo);
    check({name, "_we"}, {hi_we, lo_we}, 2'b11);
    tick();
    check({name, "_done_drop"}, {done, hi_we, lo_we, busy}, 4'b0000);
    last_hi = ehi;
    last_lo = elo;
  endtask

  initial begin
    int lat;
    logic [63:0] exp;
    logic [1:0]  o;
    logic [31:0] a, b;

    vecs[0] = '{"mult_neg",   2'b00, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA};
    vecs[1] = '{"multu_max",  2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[2] = '{"div_neg",    2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{"divu_7_2",   2'b11, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003};
    vecs[4] = '{"divu_by0",   2'b11, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF};
    vecs[5] = '{"div_ovf",    2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[6] = '{"div_by0",    2'b10, 32'h8000_0001, 32'h0000_0000, 32'h8000_0001, 32'hFFFF_FFFF};

    rst = 1'b0; start = 1'b0; op = 2'b00; src_a = '0; src_b = '0; cancel = 1'b0;
    #3;
    check("reset_outputs", {busy, done, hi_we, lo_we, hi_o, lo_o}, '0);
    tick();
    tick();
    rst = 1'b1;

    // Directed table.
    foreach (vecs[i])
      run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);

    // Randomized operations against the model.
    for (int i = 0; i < 24; i++) begin
      o = 2'($urandom);
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if (i % 5 == 1) b = 32'($urandom_range(1, 15));
      if (i % 7 == 3) a = 32'h8000_0000;
      exp = model(o, a, b);
      run_op($sformatf("rand%0d", i), o, a, b, exp[63:32], exp[31:0]);
    end

    // Start while busy is ignored and not queued.
    start = 1'b1; op = 2'b11; src_a = 32'd7; src_b = 32'd2;
    tick();
    start = 1'b0;
    repeat (5) tick();
    start = 1'b1; op = 2'b01; src_a = 32'hFFFF_FFFF; src_b = 32'hFFFF_FFFF;
    tick();
    start = 1'b0;
    wait_done(lat);
    check("busy_ign_latency", lat + 6, 32);
    check("busy_ign_result", {hi_o, lo_o}, {32'd1, 32'd3});
    last_hi = 32'd1; last_lo = 32'd3;
    expect_quiet("busy_ign", 40);

    // Cancel at iteration 10 of a MULT.
    start = 1'b1; op = 2'b00; src_a = 32'h1234_5678; src_b = 32'h9ABC_DEF0;
    tick();
    start = 1'b0;
    repeat (10) tick();
    check("cancel_busy_before", busy, 1'b1);
    cancel = 1'b1;
    tick();
    cancel = 1'b0;
    check("cancel_busy_after", busy, 1'b0);
    expect_quiet("cancel", 40);
    check("cancel_keep", {hi_o, lo_o}, {last_hi, last_lo});
    exp = model(2'b01, 32'd40000, 32'd50000);
    run_op("after_cancel", 2'b01, 32'd40000, 32'd50000, exp[63:32], exp[31:0]);

    // Start and cancel together in idle: not accepted.
    start = 1'b1; cancel = 1'b1; op = 2'b11; src_a = 32'd9; src_b = 32'd0;
    tick();
    start = 1'b0; cancel = 1'b0;
    check("start_cancel_busy", busy, 1'b0);
    expect_quiet("start_cancel", 35);

    // Asynchronous reset mid-DIV.
    start = 1'b1; op = 2'b10; src_a = 32'd1000; src_b = 32'd7;
    tick();
    start = 1'b0;
    repeat (10) tick();
    #3 rst = 1'b0;
    #1;
    check("async_reset", {busy, done, hi_we, lo_we, hi_o, lo_o}, '0);
    tick();
    tick();
    rst = 1'b1;
    expect_quiet("post_reset", 40);
    check("post_reset_busy", busy, 1'b0);

    // Start on the first edge after reset release.
    rst = 1'b0;
    tick();
    rst = 1'b1;
    exp = model(2'b10, 32'hFFFF_FF00, 32'd3);
    run_op("first_after_rst", 2'b10, 32'hFFFF_FF00, 32'd3, exp[63:32], exp[31:0]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
